frame_tx: RTL and testbench
===========================

Name: frame_tx

Overview:
- Downstream of the main control state machine.
- Consumes its response request (start_tx, cmd_tx, len_tx) and reads the response payload from the shared byte buffer RAM.
- Serializes one complete response frame (sync, cmd, len, payload, checksum) onto a byte-wide valid/ready stream that feeds the UART transmitter.
- Owns the RAM read port while busy.

Parameters:
NUMBER, 256, depth of the byte buffer RAM in bytes; address width AW = clogb2(NUMBER)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  in  1  system clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
start_tx  in  1  one-cycle pulse: send a frame
cmd_tx  in  8  command byte, sampled on start_tx
len_tx  in  8  payload length in bytes (0..255), sampled on start_tx
rd_en  out  1  RAM read strobe
rd_addr  out  AW  RAM read address
rd_data  in  8  RAM read data, valid exactly one cycle after rd_en
tx_data  out  8  stream byte
tx_valid  out  1  tx_data is valid
tx_ready  in  1  UART can accept a byte
busy  out  1  high from the cycle after an accepted start_tx until done
done  out  1  one-cycle pulse after the checksum byte transfers

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE.
  - cmd/len/index/checksum registers cleared.
- Transfer rule: a byte transfers on a rising edge where tx_valid && tx_ready.
  - Once tx_valid rises, tx_data is held stable until transfer.
  - tx_valid never drops before transfer.
  - tx_valid is not combinationally dependent on tx_ready.
- Start:
  - In IDLE, start_tx latches cmd_tx and len_tx; index=0; csum=0.
  - Go to SYNC. busy=1 from the next cycle.
  - start_tx while busy is ignored; latched values are unchanged.
- States:
  - IDLE: tx_valid=0, busy=0.
  - SYNC: tx_data=SYNC_BYTE, tx_valid=1. On transfer -> CMD.
    - tx_valid is first high the cycle after start_tx (latency 1).
  - CMD: tx_data=cmd. On transfer csum+=cmd -> LEN.
  - LEN: tx_data=len. On transfer csum+=len. If len==0 -> CSUM, else -> FETCH.
  - FETCH: rd_en=1 for exactly one cycle, rd_addr=index[AW-1:0], tx_valid=0 -> LATCH.
  - LATCH: capture rd_data into the byte register -> PAYLOAD.
  - PAYLOAD: tx_data=byte register, tx_valid=1. On transfer:
    - csum+=byte; index+=1.
    - If index+1==len -> CSUM, else -> FETCH.
  - CSUM: tx_data=csum, tx_valid=1. On transfer -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
    - A start_tx arriving in DONE is ignored; it is accepted only in IDLE.
- Arithmetic:
  - csum is 8-bit, modulo 256: sum of cmd, len and all payload bytes. SYNC_BYTE is excluded.
  - index is 8-bit. rd_addr wraps modulo NUMBER when len > NUMBER.
- Frame length is len+4 bytes.
  - With tx_ready held high: SYNC, CMD, LEN take 1 cycle each; each payload byte takes 3 cycles (FETCH, LATCH, PAYLOAD); CSUM 1 cycle.
- rd_en is 0 in every state except FETCH. rd_addr holds its last value otherwise.
- Reset mid-frame aborts immediately:
  - tx_valid=0, no done pulse.
  - The next start_tx after reset release starts a fresh frame.

Test Plan:
- cmd_tx=0x12, len_tx=3, RAM[0..2]=01 02 03, tx_ready=1 -> stream A5 12 03 01 02 03 1B; done pulses once, 1 cycle after the 0x1B transfer; tx_valid first high 1 cycle after start_tx.
- cmd_tx=0x40, len_tx=0 -> stream A5 40 00 40; rd_en never asserted; busy high for exactly 5 cycles.
- cmd_tx=0xFF, len_tx=2, RAM[0..1]=FF FF -> stream A5 FF 02 FF FF FF (checksum wraps 0x2FF->0xFF).
- len_tx=4, tx_ready toggled pseudo-randomly, held low 10 cycles during CMD -> tx_data stable while tx_valid && !tx_ready; bytes not duplicated or dropped; correct checksum.
- Second start_tx (cmd 0x99) mid-frame, and a start_tx in the DONE cycle -> both ignored; the first frame is unchanged; no second frame.
- reset asserted during PAYLOAD of a len=8 frame -> tx_valid, busy, rd_en go 0 asynchronously; no done; a subsequent start_tx with cmd 0x01, len 0 yields A5 01 00 01.

Source files
------------

// File: rtl/frame_tx.sv
// Response frame serializer: emits SYNC, cmd, len, payload read from the byte buffer RAM,
// and an 8-bit additive checksum onto a byte-wide valid/ready stream.
module frame_tx #(
    parameter int unsigned NUMBER    = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    localparam int unsigned AW       = $clog2(NUMBER)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_tx,
    input  logic [7:0]    cmd_tx,
    input  logic [7:0]    len_tx,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [3:0] {
        StIdle,
        StSync,
        StCmd,
        StLen,
        StFetch,
        StLatch,
        StPayload,
        StCsum,
        StDone
    } state_t;

    state_t     state;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] index;
    logic [7:0] csum;
    logic [7:0] pay_byte;
    logic [7:0] index_inc;
    logic       xfer;

    assign index_inc = index + 8'd1;
    assign xfer      = tx_valid & tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            cmd      <= 8'h00;
            len      <= 8'h00;
            index    <= 8'h00;
            csum     <= 8'h00;
            pay_byte <= 8'h00;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                StIdle: begin
                    if (start_tx) begin
                        cmd      <= cmd_tx;
                        len      <= len_tx;
                        index    <= 8'h00;
                        csum     <= 8'h00;
                        tx_data  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= StSync;
                    end
                end
                StSync: begin
                    if (xfer) begin
                        tx_data <= cmd;
                        state   <= StCmd;
                    end
                end
                StCmd: begin
                    if (xfer) begin
                        csum    <= csum + cmd;
                        tx_data <= len;
                        state   <= StLen;
                    end
                end
                StLen: begin
                    if (xfer) begin
                        csum <= csum + len;
                        if (len == 8'd0) begin
                            tx_data <= csum + len;
                            state   <= StCsum;
                        end else begin
                            tx_valid <= 1'b0;
                            rd_en    <= 1'b1;
                            rd_addr  <= '0;
                            state    <= StFetch;
                        end
                    end
                end
                // RAM returns data one cycle after the strobe, so LATCH samples it.
                StFetch: begin
                    state <= StLatch;
                end
                StLatch: begin
                    pay_byte <= rd_data;
                    tx_data  <= rd_data;
                    tx_valid <= 1'b1;
                    state    <= StPayload;
                end
                StPayload: begin
                    if (xfer) begin
                        csum  <= csum + pay_byte;
                        index <= index_inc;
                        if (index_inc == len) begin
                            tx_data <= csum + pay_byte;
                            state   <= StCsum;
                        end else begin
                            tx_valid <= 1'b0;
                            rd_en    <= 1'b1;
                            rd_addr  <= AW'(index_inc);
                            state    <= StFetch;
                        end
                    end
                end
                StCsum: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= StDone;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: stimulus pushes expected frame bytes, a negedge monitor
// pops and compares every transferred byte, and checks hold-stability and done timing.
module tb_frame_tx;

    logic       clk;
    logic       reset;
    logic       start_tx;
    logic [7:0] cmd_tx;
    logic [7:0] len_tx;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;

    frame_tx #(
        .NUMBER    (256),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start_tx (start_tx),
        .cmd_tx   (cmd_tx),
        .len_tx   (len_tx),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    int         total;
    int         bad;
    int         cyc;
    int         last_xfer;
    int         done_cnt;
    int         done_exp;
    int         busy_cnt;
    int         rden_cnt;
    int         rmode;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] mem [256];
    logic [7:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte buffer RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: a byte sampled here with valid&&ready transfers on the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(tx_valid), 1);
                check("hold_data", int'(tx_data), int'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_byte: got %0h want none", tx_data);
                end else begin
                    check("byte", int'(tx_data), int'(exp_q.pop_front()));
                end
                last_xfer = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done) begin
                done_cnt++;
                check("done_timing", cyc - last_xfer, 1);
                check("done_q_empty", exp_q.size(), 0);
            end
            if (busy) busy_cnt++;
            if (rd_en) rden_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: frame = SYNC, cmd, len, payload, sum(cmd,len,payload) mod 256.
    task automatic push_frame(input logic [7:0] c, input logic [7:0] l);
        logic [7:0] sum;
        sum = c + l;
        exp_q.push_back(8'hA5);
        exp_q.push_back(c);
        exp_q.push_back(l);
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back(mem[i % 256]);
            sum = sum + mem[i % 256];
        end
        exp_q.push_back(sum);
    endtask

    task automatic start_frame(input logic [7:0] c, input logic [7:0] l, input bit model);
        cmd_tx   = c;
        len_tx   = l;
        if (model) push_frame(c, l);
        start_tx = 1'b1;
        step();
        start_tx = 1'b0;
        check("start_latency", int'({tx_valid, busy, tx_data}), int'({1'b1, 1'b1, 8'hA5}));
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        check("done_timeout", int'(seen), 1);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; last_xfer = 0;
        done_cnt = 0; done_exp = 0; busy_cnt = 0; rden_cnt = 0;
        rmode = 0; prev_stall = 1'b0; prev_data = 8'h00;
        reset = 1'b1; start_tx = 1'b0; cmd_tx = 8'h00; len_tx = 8'h00;
        randomize_mem();
        #2;
        check("reset_flags", int'({tx_valid, busy, done, rd_en}), 0);
        check("reset_data", int'({tx_data, rd_addr}), 0);
        step();
        reset = 1'b0;
        step();

        // Basic frame with payload 01 02 03.
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        exp_q = '{8'hA5, 8'h12, 8'h03, 8'h01, 8'h02, 8'h03, 8'h1B};
        rden_cnt = 0;
        start_frame(8'h12, 8'd3, 1'b0);
        wait_done();
        done_exp++;
        check("t1_rden", rden_cnt, 3);
        step();

        // Empty payload.
        exp_q = '{8'hA5, 8'h40, 8'h00, 8'h40};
        busy_cnt = 0; rden_cnt = 0;
        start_frame(8'h40, 8'd0, 1'b0);
        wait_done();
        done_exp++;
        step();
        check("t2_busy_cycles", busy_cnt, 5);
        check("t2_rden", rden_cnt, 0);

        // Checksum wrap.
        mem[0] = 8'hFF; mem[1] = 8'hFF;
        exp_q = '{8'hA5, 8'hFF, 8'h02, 8'hFF, 8'hFF, 8'hFF};
        start_frame(8'hFF, 8'd2, 1'b0);
        wait_done();
        done_exp++;
        step();

        // Backpressure: ready low 10 cycles during CMD, then random.
        randomize_mem();
        start_frame(8'($urandom), 8'd4, 1'b1);
        step();
        rmode = 2;
        repeat (10) step();
        rmode = 1;
        wait_done();
        done_exp++;
        rmode = 0;
        step();

        // Random frames under random backpressure.
        for (int n = 0; n < 6; n++) begin
            randomize_mem();
            rmode = 1;
            start_frame(8'($urandom), 8'($urandom_range(0, 20)), 1'b1);
            wait_done();
            done_exp++;
            rmode = 0;
            step();
        end

        // Longest payload.
        randomize_mem();
        start_frame(8'($urandom), 8'd255, 1'b1);
        wait_done();
        done_exp++;
        step();

        // start_tx mid-frame and in the DONE cycle are ignored.
        randomize_mem();
        rmode = 1;
        start_frame(8'h3C, 8'd3, 1'b1);
        repeat (4) step();
        cmd_tx = 8'h99; len_tx = 8'd7; start_tx = 1'b1;
        step();
        start_tx = 1'b0;
        wait_done();
        done_exp++;
        rmode = 0;
        cmd_tx = 8'h99; len_tx = 8'd5; start_tx = 1'b1;
        step();
        start_tx = 1'b0;
        repeat (3) step();
        check("done_start_busy", int'(busy), 0);
        check("done_start_valid", int'(tx_valid), 0);
        repeat (12) step();

        // Reset during PAYLOAD aborts the frame.
        randomize_mem();
        start_frame(8'h77, 8'd8, 1'b1);
        repeat (5) step();
        check("pre_reset_valid", int'(tx_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_flags", int'({tx_valid, busy, rd_en, done}), 0);
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        exp_q = '{8'hA5, 8'h01, 8'h00, 8'h01};
        start_frame(8'h01, 8'd0, 1'b0);
        wait_done();
        done_exp++;
        repeat (3) step();

        check("done_count", done_cnt, done_exp);
        check("final_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
